// File: rtl/wb_initiator_pkg.sv
// wb_initiator_pkg
// Shared definitions for the single-transaction Wishbone initiator:
//   - state_e                : FSM state encoding (IDLE / BUS / RESP)
//   - DEF_TIMEOUT            : default last counter value at which ACK is accepted
//   - DEF_TIMEOUT_READ_VALUE : default response data returned on a timeout
package wb_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int          DEF_TIMEOUT            = 15;
  localparam logic [31:0] DEF_TIMEOUT_READ_VALUE = 32'hBADFABAC;

endpackage

// File: rtl/wb_initiator.sv
// wb_initiator
// Converts a valid/ready command into a single Wishbone classic cycle and
// returns the result on a valid/ready response channel. One transaction is
// outstanding at a time. A bus cycle that sees no ACK within TIMEOUT+1 cycles
// is abandoned and reported with rsp_err_o = 1.
//
// Ports
//   WBs_CLK_i, WBs_RST_i       : clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o  : command handshake (ready only in IDLE)
//   cmd_we_i, cmd_adr_i,
//   cmd_byte_stb_i, cmd_dat_i  : command fields, latched on acceptance
//   rsp_valid_o / rsp_ready_i  : response handshake
//   rsp_dat_o, rsp_err_o       : response data and timeout flag
//   WBm_*                      : registered Wishbone master signals
//   busy_o                     : high whenever the FSM is not IDLE
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int                   ADDRWIDTH          = 17,
  parameter int                   DATAWIDTH          = 32,
  parameter int                   TIMEOUT_CNTR_WIDTH = 4,
  parameter int                   TIMEOUT            = DEF_TIMEOUT,
  parameter logic [DATAWIDTH-1:0] TIMEOUT_READ_VALUE = DATAWIDTH'(DEF_TIMEOUT_READ_VALUE)
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,

  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADDRWIDTH-1:0] cmd_adr_i,
  input  logic [3:0]           cmd_byte_stb_i,
  input  logic [DATAWIDTH-1:0] cmd_dat_i,

  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATAWIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,

  output logic [ADDRWIDTH-1:0] WBm_ADR_o,
  output logic                 WBm_CYC_o,
  output logic                 WBm_STB_o,
  output logic                 WBm_WE_o,
  output logic                 WBm_RD_o,
  output logic [3:0]           WBm_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] WBm_WR_DAT_o,
  input  logic [DATAWIDTH-1:0] WBm_RD_DAT_i,
  input  logic                 WBm_ACK_i,

  output logic                 busy_o
);

  localparam logic [TIMEOUT_CNTR_WIDTH-1:0] CNT_LAST = TIMEOUT_CNTR_WIDTH'(TIMEOUT);
  localparam logic [TIMEOUT_CNTR_WIDTH-1:0] CNT_ONE  = TIMEOUT_CNTR_WIDTH'(1);

  state_e                        state_q, state_d;
  logic [TIMEOUT_CNTR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDRWIDTH-1:0]          adr_q, adr_d;
  logic                          cyc_q, cyc_d;
  logic                          we_q, we_d;
  logic                          rd_q, rd_d;
  logic [3:0]                    bstb_q, bstb_d;
  logic [DATAWIDTH-1:0]          wdat_q, wdat_d;
  logic [DATAWIDTH-1:0]          rsp_dat_q, rsp_dat_d;
  logic                          rsp_err_q, rsp_err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    rd_d      = rd_q;
    bstb_d    = bstb_q;
    wdat_d    = wdat_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;

    case (state_q)
      IDLE: begin
        // cmd_ready_o is 1 in IDLE, so cmd_valid_i alone completes the handshake
        if (cmd_valid_i) begin
          state_d = BUS;
          cnt_d   = '0;
          adr_d   = {cmd_adr_i[ADDRWIDTH-1:2], 2'b00};  // word-aligned bus address
          cyc_d   = 1'b1;
          we_d    = cmd_we_i;
          rd_d    = ~cmd_we_i;
          bstb_d  = cmd_we_i ? cmd_byte_stb_i : 4'hF;   // reads always fetch the full word
          wdat_d  = cmd_dat_i;
        end
      end

      BUS: begin
        // ACK is tested first so that an ACK arriving on the last allowed
        // cycle is still taken as a normal completion.
        if (WBm_ACK_i) begin
          state_d   = RESP;
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          rd_d      = 1'b0;
          bstb_d    = 4'h0;
          rsp_dat_d = rd_q ? WBm_RD_DAT_i : '0;
          rsp_err_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RESP;
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          rd_d      = 1'b0;
          bstb_d    = 4'h0;
          rsp_dat_d = TIMEOUT_READ_VALUE;
          rsp_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      adr_q     <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      rd_q      <= 1'b0;
      bstb_q    <= 4'h0;
      wdat_q    <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      bstb_q    <= bstb_d;
      wdat_q    <= wdat_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign cmd_ready_o    = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign rsp_valid_o    = (state_q == RESP);
  assign rsp_dat_o      = rsp_dat_q;
  assign rsp_err_o      = rsp_err_q;

  assign WBm_ADR_o      = adr_q;
  assign WBm_CYC_o      = cyc_q;
  assign WBm_STB_o      = cyc_q;
  assign WBm_WE_o       = we_q;
  assign WBm_RD_o       = rd_q;
  assign WBm_BYTE_STB_o = bstb_q;
  assign WBm_WR_DAT_o   = wdat_q;

endmodule

// File: tb/tb_wb_initiator.sv
module tb_wb_initiator;

  logic        clk = 1'b0;
  logic        srst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [16:0] cmd_adr;
  logic [3:0]  cmd_bstb;
  logic [31:0] cmd_dat;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic [16:0] wb_adr;
  logic        wb_cyc, wb_stb, wb_we, wb_rd, wb_ack;
  logic [3:0]  wb_bstb;
  logic [31:0] wb_wdat, wb_rdat;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_initiator dut (
    .WBs_CLK_i      (clk),
    .WBs_RST_i      (srst),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_we_i       (cmd_we),
    .cmd_adr_i      (cmd_adr),
    .cmd_byte_stb_i (cmd_bstb),
    .cmd_dat_i      (cmd_dat),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_dat_o      (rsp_dat),
    .rsp_err_o      (rsp_err),
    .WBm_ADR_o      (wb_adr),
    .WBm_CYC_o      (wb_cyc),
    .WBm_STB_o      (wb_stb),
    .WBm_WE_o       (wb_we),
    .WBm_RD_o       (wb_rd),
    .WBm_BYTE_STB_o (wb_bstb),
    .WBm_WR_DAT_o   (wb_wdat),
    .WBm_RD_DAT_i   (wb_rdat),
    .WBm_ACK_i      (wb_ack),
    .busy_o         (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ack_dly: BUS cycle index (0 = first STB cycle) on which ACK is driven; -1 = never
  typedef struct {
    logic        we;
    logic [16:0] adr;
    logic [3:0]  bstb;
    logic [31:0] dat;
    int          ack_dly;
    logic [31:0] rd_dat;
    logic [16:0] e_adr;
    logic [3:0]  e_bstb;
    logic [31:0] e_rsp;
    logic        e_err;
    int          e_cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input int idx, input vec_t v);
    int ncyc;
    int guard;
    logic [31:0] held;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_we    = v.we;
    cmd_adr   = v.adr;
    cmd_bstb  = v.bstb;
    cmd_dat   = v.dat;
    @(negedge clk);
    cmd_valid = 1'b0;
    // first BUS cycle: check the latched bus fields
    chk("stb",      wb_stb,  1);
    chk("busy",     busy,    1);
    chk("cmd_rdy0", cmd_ready, 0);
    chk("adr",      wb_adr,  v.e_adr);
    chk("we",       wb_we,   v.we);
    chk("rd",       wb_rd,   !v.we);
    chk("bstb",     wb_bstb, v.e_bstb);
    if (v.we) chk("wdat", wb_wdat, v.dat);
    ncyc  = 0;
    guard = 0;
    while (wb_cyc && guard < 40) begin
      wb_ack  = (ncyc == v.ack_dly);
      wb_rdat = v.rd_dat;
      ncyc++;
      guard++;
      @(negedge clk);
    end
    wb_ack  = 1'b0;
    wb_rdat = 32'h0;
    chk("cyc_cycles", 64'(ncyc), 64'(v.e_cyc));
    chk("bus_idle_bstb", wb_bstb, 0);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_dat",   rsp_dat,   v.e_rsp);
    chk("rsp_err",   rsp_err,   v.e_err);
    held = rsp_dat;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", rsp_valid, 0);
    chk("cmd_ready_back", cmd_ready, 1);
    $display("vec %0d we=%0b adr=%05h -> bus_adr=%05h cyc=%0d rsp=%08h err=%0b",
             idx, v.we, v.adr, v.e_adr, ncyc, held, v.e_err);
  endtask

  initial begin
    logic [31:0] first_dat;
    logic        saw_valid;

    vecs[0] = '{1'b0, 17'h01004, 4'h0,    32'h0,          2, 32'h0000_00A5, 17'h01004, 4'hF,    32'h0000_00A5, 1'b0, 3};
    vecs[1] = '{1'b1, 17'h02003, 4'b0001, 32'h1234_5678,  0, 32'hFFFF_FFFF, 17'h02000, 4'b0001, 32'h0,         1'b0, 1};
    vecs[2] = '{1'b0, 17'h00010, 4'h0,    32'h0,         -1, 32'h1111_1111, 17'h00010, 4'hF,    32'hBADF_ABAC, 1'b1, 16};
    vecs[3] = '{1'b0, 17'h1FFFF, 4'h3,    32'h0,         15, 32'hDEAD_BEEF, 17'h1FFFC, 4'hF,    32'hDEAD_BEEF, 1'b0, 16};
    vecs[4] = '{1'b1, 17'h00007, 4'b1100, 32'hCAFE_F00D,  5, 32'h0000_0001, 17'h00004, 4'b1100, 32'h0,         1'b0, 6};
    vecs[5] = '{1'b1, 17'h0ABCD, 4'b1111, 32'h5555_AAAA, -1, 32'h0,         17'h0ABCC, 4'b1111, 32'hBADF_ABAC, 1'b1, 16};

    srst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_bstb = '0;
    cmd_dat = '0; rsp_ready = 1'b0; wb_ack = 1'b0; wb_rdat = '0;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy",      busy,      0);
    chk("rst_cyc",       wb_cyc,    0);
    chk("rst_stb",       wb_stb,    0);
    chk("rst_we",        wb_we,     0);
    chk("rst_rd",        wb_rd,     0);
    chk("rst_bstb",      wb_bstb,   0);
    chk("rst_adr",       wb_adr,    0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_dat",   rsp_dat,   0);
    chk("rst_rsp_err",   rsp_err,   0);
    $display("reset state checked");

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Response back-pressure: rsp_ready low for 5 cycles, stray ACK and command ignored
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 17'h00100;
    @(negedge clk);
    cmd_valid = 1'b0;
    wb_ack = 1'b1; wb_rdat = 32'h1111_2222;
    @(negedge clk);
    chk("bp_valid0", rsp_valid, 1);
    first_dat = rsp_dat;
    chk("bp_dat0", rsp_dat, 32'h1111_2222);
    wb_rdat = 32'h9999_8888;     // ACK still high with different data
    cmd_valid = 1'b1; cmd_adr = 17'h00200;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid",     rsp_valid, 1);
      chk("bp_dat",       rsp_dat,   32'h1111_2222);
      chk("bp_err",       rsp_err,   0);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_cyc",       wb_cyc,    0);
    end
    wb_ack = 1'b0; cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_release", rsp_valid, 0);
    chk("bp_idle",    busy,      0);
    $display("backpressure held rsp=%08h for 5 cycles", first_dat);

    // Minimum latency with rsp_ready held high
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 17'h00020;
    @(negedge clk);                          // cycle 1
    cmd_valid = 1'b0;
    chk("lat_cyc1", wb_cyc, 1);
    wb_ack = 1'b1; wb_rdat = 32'h5A5A_5A5A;
    @(negedge clk);                          // cycle 2
    wb_ack = 1'b0;
    chk("lat_cyc2_low", wb_cyc,    0);
    chk("lat_valid2",   rsp_valid, 1);
    chk("lat_dat2",     rsp_dat,   32'h5A5A_5A5A);
    @(negedge clk);                          // cycle 3
    chk("lat_ready3",   cmd_ready, 1);
    chk("lat_valid3",   rsp_valid, 0);
    rsp_ready = 1'b0;
    $display("min latency sequence checked");

    // Reset in the middle of a bus cycle
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 17'h00300;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_cyc_before", wb_cyc, 1);
    repeat (2) @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    chk("mid_cyc",   wb_cyc,    0);
    chk("mid_stb",   wb_stb,    0);
    chk("mid_ready", cmd_ready, 1);
    chk("mid_busy",  busy,      0);
    rsp_ready = 1'b1;
    saw_valid = 1'b0;
    wb_ack = 1'b1; wb_rdat = 32'h7777_7777;  // late ACK must be ignored in IDLE
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      wb_ack = 1'b0;
      if (rsp_valid) saw_valid = 1'b1;
    end
    rsp_ready = 1'b0;
    chk("mid_no_rsp", saw_valid, 0);
    chk("mid_still_idle", cmd_ready, 1);
    $display("reset mid-BUS checked");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
